match_counter: RTL and testbench
================================

# match_counter

Parametrised counter-compare unit: a free-standing up-counter is compared each cycle against a programmable compare register, and a one-cycle registered match pulse is raised on equality. It generalises the 4-bit data/count equality comparator to WIDTH bits. It adds a counter, a load path for the compare value, and three run modes: one-shot, periodic and free-run. It sits beside the existing combinational comparators as the timing/event source for the lab datapath.

## Interface
- WIDTH, 8, bit width of counter, compare register and data input (legal 2..32)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- data  input  WIDTH  compare value, captured on load
- load  input  1  capture data into compare register (IDLE/DONE only)
- start  input  1  clear counter and enter RUN
- stop  input  1  abort to IDLE, counter held
- mode  input  2  00 one-shot, 01 periodic, 10 free-run, 11 reserved (treated as one-shot)
- count  output  WIDTH  current counter value
- out  output  1  registered match pulse, one cycle wide
- busy  output  1  high in RUN
- done  output  1  high in DONE (one-shot finished)

## Operation
- Reset: state IDLE, count=0, compare register=0, out=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - load=1 -> compare register <= data.
  - start=1 -> count <= 0, RUN.
- RUN, every edge, with eq = (count == compare register) evaluated combinationally:
  - eq=0 -> count <= count+1, modulo 2^WIDTH.
  - eq=1, one-shot -> out <= 1, count held, state DONE.
  - eq=1, periodic -> out <= 1, count <= 0.
  - eq=1, free-run -> out <= 1, count <= count+1 (wraps max -> 0).
- DONE:
  - count held.
  - start=1 -> count <= 0, RUN.
  - load accepted.
  - stop -> IDLE.
- Mode is sampled only at the start edge and held internally for the run. Mode changes during RUN have no effect.
- load in RUN is ignored; the compare register is unchanged.
- stop has priority over start and load in every state:
  - any state -> IDLE, count held, out <= 0.
- start in RUN (without stop) restarts: count <= 0, mode resampled, no match pulse that edge.
- Compare value 0:
  - one-shot: match on the first RUN edge.
  - periodic: out high every cycle, count stays 0.
- Arithmetic is unsigned. The counter wraps silently with no overflow flag.

## Timing
- Start sampled at edge k -> busy=1 and count=0 from edge k.
- Compare value N:
  - out is high for exactly the one cycle following edge k+N+1.
  - one-shot: done=1 from edge k+N+1.
  - periodic: period N+1 cycles.
  - free-run: period 2^WIDTH cycles.
- out is a flop output. It is never high two consecutive cycles except in periodic mode with compare value 0.
- Load at edge j affects the compare from edge j+1.
- Async reset mid-run: all outputs return to their reset values immediately. The first start after rst_n release behaves as from power-up.

## Structure
- Shared package match_pkg:
  - mode encodings MODE_ONESHOT, MODE_PERIODIC, MODE_FREERUN.
  - state enum IDLE/RUN/DONE.
- One sub-module, comparator_n: parametrised WIDTH equality comparator (XOR per bit, NOR reduce), the direct generalisation of the 4-bit equality comparator.
- Top level contains the FSM, counter, compare register and out flop.

## Test plan
- WIDTH=4, load 5, one-shot, start at edge 0 -> count 0..5, out high only the cycle after edge 6, done=1, count holds 5, busy=0.
- Load 3, periodic -> count sequence 0,1,2,3,0,1,..., out pulses every 4 cycles, four pulses observed in 16 cycles.
- Load 2, free-run -> count wraps 15->0, out pulses every 16 cycles, first pulse after edge 3.
- Load 0, one-shot -> out after edge 1, done=1. Same value in periodic -> out continuously high, count stays 0.
- In RUN, load 9 -> compare register unchanged. Start+stop same edge in IDLE -> stays IDLE, busy=0. Stop at count=7 -> IDLE, count stays 7.
- rst_n low at count=4 in RUN -> count=0, out=0, busy=0, compare register=0 immediately. Restart after release matches power-up behaviour.

Source files
------------

// File: rtl/match_counter_pkg.sv
// Shared definitions for the counter-compare unit: run-mode encodings and FSM states.
package match_pkg;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_FREERUN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/match_counter_if.sv
// Control/status bundle of match_counter; master drives controls, slave is the counter.
interface match_counter_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] count;
  logic             out;
  logic             busy;
  logic             done;

  modport master (output data, load, start, stop, mode,
                  input  count, out, busy, done);
  modport slave  (input  data, load, start, stop, mode,
                  output count, out, busy, done);
endinterface

// File: rtl/match_counter_comparator_n.sv
// WIDTH-bit equality comparator: per-bit XOR, then NOR-reduce.
module comparator_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  assign eq_o = ~|(a_i ^ b_i);

endmodule

// File: rtl/match_counter.sv
// Counter-compare unit: up-counter checked against a loadable compare register,
// registered one-cycle match pulse, one-shot / periodic / free-run modes.
module match_counter
  import match_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  match_counter_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q,   cmp_d;
  logic [1:0]       mode_q,  mode_d;
  logic             out_q,   out_d;
  logic             eq;

  comparator_n #(.WIDTH(WIDTH)) u_cmp (
    .a_i  (count_q),
    .b_i  (cmp_q),
    .eq_o (eq)
  );

  // Next-state: stop wins over everything; restart in RUN suppresses the match that edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    mode_d  = mode_q;
    out_d   = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.load) cmp_d = bus.data;
          if (bus.start) begin
            count_d = '0;
            mode_d  = bus.mode;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.start) begin
            count_d = '0;
            mode_d  = bus.mode;
          end else if (eq) begin
            out_d = 1'b1;
            case (mode_q)
              MODE_PERIODIC: count_d = '0;
              MODE_FREERUN:  count_d = count_q + WIDTH'(1);
              // one-shot and the reserved encoding both finish here
              default:       state_d = DONE;
            endcase
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter, compare register, latched mode and match flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      cmp_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign bus.count = count_q;
  assign bus.out   = out_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_match_counter.sv
// Directed bench for match_counter (WIDTH=4) with a spec-level model feeding a scoreboard.
module tb_match_counter;
  import match_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_counter_if #(.WIDTH(W)) bus ();

  match_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] count;
    logic         out;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   pulses = 0;

  // reference model state
  state_e       m_state = IDLE;
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_cmp = '0;
  logic [1:0]   m_mode = MODE_ONESHOT;
  logic         m_out = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, compare after the edge.
  task automatic step(input logic ld, input logic st, input logic sp,
                      input logic [1:0] md, input logic [W-1:0] d);
    exp_t e;
    bus.load = ld; bus.start = st; bus.stop = sp; bus.mode = md; bus.data = d;
    m_out = 1'b0;
    if (sp) m_state = IDLE;
    else if (m_state == RUN) begin
      if (st) begin
        m_cnt = '0; m_mode = md;
      end else if (m_cnt == m_cmp) begin
        m_out = 1'b1;
        if (m_mode == MODE_PERIODIC)     m_cnt = '0;
        else if (m_mode == MODE_FREERUN) m_cnt = m_cnt + 1'b1;
        else                             m_state = DONE;
      end else m_cnt = m_cnt + 1'b1;
    end else begin
      if (ld) m_cmp = d;
      if (st) begin m_cnt = '0; m_mode = md; m_state = RUN; end
    end
    sb.push_back('{count: m_cnt, out: m_out, busy: (m_state == RUN), done: (m_state == DONE)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("count", 32'(bus.count), 32'(e.count));
    check("out",   32'(bus.out),   32'(e.out));
    check("busy",  32'(bus.busy),  32'(e.busy));
    check("done",  32'(bus.done),  32'(e.done));
    if (bus.out) pulses++;
  endtask

  task automatic idle(input int n, input logic [1:0] md);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, md, '0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_out"},   32'(bus.out),   32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'b00; bus.data = '0;
    #12;
    check_reset_vals("por");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // one-shot, compare 5
    step(1'b1, 1'b0, 1'b0, MODE_ONESHOT, 4'd5);
    step(1'b0, 1'b1, 1'b0, MODE_ONESHOT, 4'd0);
    pulses = 0;
    idle(5, MODE_ONESHOT);
    check("os5_no_early_pulse", 32'(pulses), 32'd0);
    idle(1, MODE_ONESHOT);
    check("os5_out_after_edge6", 32'(bus.out), 32'd1);
    idle(1, MODE_ONESHOT);
    check("os5_pulses", 32'(pulses), 32'd1);
    check("os5_hold_count", 32'(bus.count), 32'd5);
    check("os5_done", 32'(bus.done), 32'd1);

    // periodic, compare 3 (load accepted in DONE)
    step(1'b1, 1'b0, 1'b0, MODE_ONESHOT, 4'd3);
    step(1'b0, 1'b1, 1'b0, MODE_PERIODIC, 4'd0);
    pulses = 0;
    idle(16, MODE_PERIODIC);
    check("per3_pulses_16cyc", 32'(pulses), 32'd4);

    // free-run, compare 2; mode input wiggles mid-run and must be ignored
    step(1'b0, 1'b0, 1'b1, MODE_ONESHOT, 4'd0);
    step(1'b1, 1'b0, 1'b0, MODE_ONESHOT, 4'd2);
    step(1'b0, 1'b1, 1'b0, MODE_FREERUN, 4'd0);
    pulses = 0;
    idle(3, MODE_ONESHOT);
    check("fr2_first_pulse", 32'(bus.out), 32'd1);
    idle(32, MODE_PERIODIC);
    check("fr2_pulses", 32'(pulses), 32'd3);

    // compare 0: one-shot matches on first edge; periodic holds out high
    step(1'b0, 1'b0, 1'b1, MODE_ONESHOT, 4'd0);
    step(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 4'd0);
    step(1'b0, 1'b0, 1'b0, MODE_ONESHOT, 4'd0);
    check("os0_out", 32'(bus.out), 32'd1);
    check("os0_done", 32'(bus.done), 32'd1);
    step(1'b0, 1'b1, 1'b0, MODE_PERIODIC, 4'd0);
    pulses = 0;
    idle(5, MODE_PERIODIC);
    check("per0_pulses", 32'(pulses), 32'd5);

    // load during RUN ignored: compare stays 8
    step(1'b0, 1'b0, 1'b1, MODE_ONESHOT, 4'd0);
    step(1'b1, 1'b1, 1'b0, MODE_PERIODIC, 4'd8);
    idle(3, MODE_PERIODIC);
    step(1'b1, 1'b0, 1'b0, MODE_PERIODIC, 4'd9);
    pulses = 0;
    idle(5, MODE_PERIODIC);
    check("runload_pulse_at_8", 32'(pulses), 32'd1);

    // start+stop in IDLE stays idle
    step(1'b0, 1'b0, 1'b1, MODE_ONESHOT, 4'd0);
    step(1'b0, 1'b1, 1'b1, MODE_ONESHOT, 4'd0);
    check("startstop_busy", 32'(bus.busy), 32'd0);

    // stop at count 7 holds count
    step(1'b1, 1'b1, 1'b0, MODE_ONESHOT, 4'd15);
    idle(7, MODE_ONESHOT);
    step(1'b0, 1'b0, 1'b1, MODE_ONESHOT, 4'd0);
    check("stop7_count", 32'(bus.count), 32'd7);
    check("stop7_busy", 32'(bus.busy), 32'd0);

    // restart in RUN: count clears, no pulse that edge
    step(1'b1, 1'b1, 1'b0, MODE_PERIODIC, 4'd10);
    idle(4, MODE_PERIODIC);
    step(1'b0, 1'b1, 1'b0, MODE_ONESHOT, 4'd0);
    check("restart_count", 32'(bus.count), 32'd0);

    // async reset mid-run at count 4
    idle(4, MODE_ONESHOT);
    check("pre_rst_count", 32'(bus.count), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    m_state = IDLE; m_cnt = '0; m_cmp = '0; m_mode = MODE_ONESHOT; m_out = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // compare register back to 0: one-shot matches on the first RUN edge
    step(1'b0, 1'b1, 1'b0, MODE_ONESHOT, 4'd0);
    step(1'b0, 1'b0, 1'b0, MODE_ONESHOT, 4'd0);
    check("post_rst_out", 32'(bus.out), 32'd1);
    check("post_rst_done", 32'(bus.done), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
